dec3_8_strobe: RTL and testbench
================================

// Module: dec3_8_strobe
// PURPOSE
//   Registered 3-to-8 decoder with a valid/ready handshake and a timed output strobe.
//   Accepts a 3-bit code and drives the matching one-hot line of y for PULSE_LEN cycles.
//   Then drops y to zero, pulses done, and accepts the next code.
//   Inverse of the 8:3 encoder path: turns encoded select codes back into per-line strobes.
// PARAMETERS
//   PULSE_LEN  4  cycles y stays one-hot per accepted code; legal range 1..255
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous reset, active-high
//   enb         in   1  block enable; low = no accept, abort active strobe
//   code        in   3  binary line select, sampled on accept
//   code_valid  in   1  code is valid this cycle
//   code_ready  out  1  block can accept a code this cycle
//   y           out  8  registered one-hot output, 8'h00 when idle
//   busy        out  1  high while y is driven non-zero
//   done        out  1  1-cycle pulse after a strobe completes normally
// BEHAVIOUR
//   Clocking and reset
//   - One clock. Reset is synchronous and active-high.
//   - rst has priority over all other inputs: state=IDLE, y=8'h00, busy=0, done=0, counter=0.
//   - code_ready is combinational: (state==IDLE) & enb & ~rst. It is 0 during reset.
//   State machine: IDLE, ACTIVE
//   - IDLE -> ACTIVE on accept (code_valid & code_ready).
//     Next cycle: y = 8'b1 << code, busy=1, cnt = PULSE_LEN-1.
//   - ACTIVE with enb=1 and cnt!=0: cnt decrements; y and busy hold.
//   - ACTIVE with enb=1 and cnt==0: next cycle state=IDLE, y=0, busy=0, done=1.
//   - ACTIVE with enb=0 (abort): next cycle state=IDLE, y=0, busy=0, done=0.
//     Abort takes effect regardless of cnt.
//   Timing
//   - Accept-to-y latency is 1 cycle. y is non-zero for exactly PULSE_LEN cycles.
//   - done is asserted only in the IDLE cycle immediately after a normal completion.
//   - In that same done cycle, code_ready=enb, so back-to-back accept is allowed.
//   - Minimum gap between consecutive strobes is one y=0 cycle.
//   Handshake and data rules
//   - code_valid while code_ready=0 is ignored. No queuing; the upstream holds the code.
//   - code is captured only on accept; code changes during ACTIVE do not affect y.
//   - y is always 8'h00 or exactly one bit set. Never more than one bit.
//   - cnt width is 8 bits. PULSE_LEN=1 gives a single-cycle strobe (cnt loaded 0).
//   - enb low in IDLE: no accept and outputs stay zero. This matches the encoder's disabled-zero convention.
//   - rst asserted mid-strobe: y=0 next cycle, no done pulse.
// TESTING
//   1. rst=1 for 2 cycles with code_valid=1 -> y=8'h00, busy=0, done=0, code_ready=0 throughout.
//   2. PULSE_LEN=4, enb=1, code=3'b101 accepted at cycle T
//      -> y=8'b0010_0000 and busy=1 during T+1..T+4; y=0 and done=1 at T+5.
//   3. Back-to-back: code 3'b000 then 3'b111 held valid
//      -> y=8'h01 for 4 cycles; one cycle of y=0 with done=1 and the accept; then y=8'h80 for 4 cycles.
//   4. Abort: accept 3'b011, drop enb at the 2nd ACTIVE cycle
//      -> y=0 and busy=0 next cycle; done stays 0; code_ready=0 until enb=1.
//   5. PULSE_LEN=1, sweep codes 0..7 continuously valid
//      -> each y = 1<<code for one cycle, alternating with done cycles; one-hot check on every cycle.
//   6. Reset mid-strobe (rst at the 3rd ACTIVE cycle)
//      -> y=0 next cycle with no done pulse; the first accept after reset behaves as in test 2.

Source files
------------

// File: rtl/dec3_8_strobe_if.sv
// dec3_8_strobe_if: code handshake and strobe outputs of the 3-to-8 strobe decoder
interface dec3_8_strobe_if;
  logic       enb;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] y;
  logic       busy;
  logic       done;
  modport master (output enb, code, code_valid, input code_ready, y, busy, done);
  modport slave (input enb, code, code_valid, output code_ready, y, busy, done);
endinterface

// File: rtl/dec3_8_strobe.sv
// dec3_8_strobe: registered 3-to-8 decoder holding a one-hot strobe for PULSE_LEN cycles
module dec3_8_strobe #(
  parameter int PULSE_LEN = 4
) (
  input logic clk,
  input logic rst,
  dec3_8_strobe_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  logic [0:0] state;
  logic [7:0] cnt;
  assign bus.code_ready = (state == IDLE) & bus.enb & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      bus.y <= 8'h00;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.code_valid && bus.code_ready) begin
          state <= ACTIVE;
          bus.y <= 8'b1 << bus.code;
          bus.busy <= 1'b1;
          cnt <= 8'(PULSE_LEN - 1);
        end
      end else if (!bus.enb || cnt == 8'd0) begin
        // abort and normal completion both clear the strobe; only completion reports done
        state <= IDLE;
        bus.y <= 8'h00;
        bus.busy <= 1'b0;
        bus.done <= bus.enb;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_dec3_8_strobe.sv
// tb_dec3_8_strobe: directed vectors for the strobe decoder at PULSE_LEN 4 and 1
module tb_dec3_8_strobe;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  dec3_8_strobe_if b4 ();
  dec3_8_strobe_if b1 ();
  dec3_8_strobe #(.PULSE_LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  dec3_8_strobe #(.PULSE_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic out4(input string t, input logic [7:0] y, input logic busy, input logic done);
    check({t, " y"}, 32'(b4.y), 32'(y));
    check({t, " busy"}, 32'(b4.busy), 32'(busy));
    check({t, " done"}, 32'(b4.done), 32'(done));
    check({t, " onehot"}, 32'($countones(b4.y) <= 1), 32'd1);
  endtask
  task automatic rdy4(input string t, input logic exp);
    #1;
    check({t, " ready"}, 32'(b4.code_ready), 32'(exp));
  endtask
  task automatic run_strobe(input logic [2:0] c, input string t);
    b4.enb = 1'b1;
    b4.code = c;
    b4.code_valid = 1'b1;
    rdy4(t, 1'b1);
    cyc();
    b4.code_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out4(t, 8'b1 << c, 1'b1, 1'b0);
      cyc();
    end
    out4({t, " end"}, 8'h00, 1'b0, 1'b1);
    cyc();
    out4({t, " after"}, 8'h00, 1'b0, 1'b0);
  endtask
  initial begin
    rst = 1'b1;
    b4.enb = 1'b1; b4.code = 3'd2; b4.code_valid = 1'b1;
    b1.enb = 1'b1; b1.code = 3'd2; b1.code_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      out4("reset", 8'h00, 1'b0, 1'b0);
      check("reset ready", 32'(b4.code_ready), 32'd0);
    end
    b4.code_valid = 1'b0;
    b1.code_valid = 1'b0;
    rst = 1'b0;
    cyc();
    out4("idle", 8'h00, 1'b0, 1'b0);
    run_strobe(3'd5, "basic");
    // back-to-back: 0 then 7 held valid
    b4.code = 3'd0;
    b4.code_valid = 1'b1;
    cyc();
    b4.code = 3'd7;
    rdy4("b2b active", 1'b0);
    for (int i = 0; i < 4; i++) begin
      out4("b2b first", 8'h01, 1'b1, 1'b0);
      cyc();
    end
    out4("b2b gap", 8'h00, 1'b0, 1'b1);
    rdy4("b2b gap", 1'b1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      out4("b2b second", 8'h80, 1'b1, 1'b0);
      cyc();
    end
    b4.code_valid = 1'b0;
    out4("b2b end", 8'h00, 1'b0, 1'b1);
    cyc();
    // abort at the 2nd active cycle
    b4.code = 3'd3;
    b4.code_valid = 1'b1;
    cyc();
    b4.code_valid = 1'b0;
    out4("abort act1", 8'h08, 1'b1, 1'b0);
    cyc();
    out4("abort act2", 8'h08, 1'b1, 1'b0);
    b4.enb = 1'b0;
    cyc();
    out4("abort", 8'h00, 1'b0, 1'b0);
    b4.code = 3'd2;
    b4.code_valid = 1'b1;
    rdy4("abort disabled", 1'b0);
    cyc();
    out4("abort hold", 8'h00, 1'b0, 1'b0);
    cyc();
    out4("disabled idle", 8'h00, 1'b0, 1'b0);
    b4.code_valid = 1'b0;
    b4.enb = 1'b1;
    cyc();
    // PULSE_LEN=1 sweep with code_valid held high
    b1.code_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b1.code = 3'(k);
      #1;
      check("sweep ready", 32'(b1.code_ready), 32'd1);
      cyc();
      check("sweep y", 32'(b1.y), 32'(8'b1 << k));
      check("sweep busy", 32'(b1.busy), 32'd1);
      check("sweep done", 32'(b1.done), 32'd0);
      check("sweep onehot", 32'($countones(b1.y)), 32'd1);
      cyc();
      check("sweep gap y", 32'(b1.y), 32'd0);
      check("sweep gap done", 32'(b1.done), 32'd1);
    end
    b1.code_valid = 1'b0;
    cyc();
    check("sweep idle done", 32'(b1.done), 32'd0);
    // reset at the 3rd active cycle
    b4.code = 3'd6;
    b4.code_valid = 1'b1;
    cyc();
    b4.code_valid = 1'b0;
    out4("rstmid act1", 8'h40, 1'b1, 1'b0);
    cyc();
    out4("rstmid act2", 8'h40, 1'b1, 1'b0);
    cyc();
    out4("rstmid act3", 8'h40, 1'b1, 1'b0);
    rst = 1'b1;
    rdy4("rstmid", 1'b0);
    cyc();
    out4("rstmid", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    out4("rstmid after", 8'h00, 1'b0, 1'b0);
    run_strobe(3'd5, "post rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
